// File: rtl/rv_pipelined_shifter_if.sv
// Request/result handshake bundle for rv_pipelined_shifter.
// master = producer/consumer side, slave = the shift unit.
interface rv_pipelined_shifter_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic             in_imm;
  logic [31:0]      in_instr;
  logic [XLEN-1:0]  in_rs1;
  logic [XLEN-1:0]  in_rs2;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_data;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_op, in_imm, in_instr, in_rs1, in_rs2, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag
  );

  modport slave (
    input  in_valid, in_op, in_imm, in_instr, in_rs1, in_rs2, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag
  );
endinterface

// File: rtl/rv_pipelined_shifter.sv
// Pipelined RV32/RV64 SLL/SRL/SRA unit with valid/ready, tag carry and flush.
// Define RV_SHIFTER_ROTATE_EN to make op 2'b10 a rotate-right (Zbb ROR); otherwise it aliases SLL.
module rv_pipelined_shifter #(
  parameter int XLEN        = 32,
  parameter int PIPE_STAGES = 2,
  parameter int TAG_W       = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  rv_pipelined_shifter_if.slave bus
);
  localparam int SHW = $clog2(XLEN);
  // Mux levels per stage; later stages may end up with fewer (or none).
  localparam int LPS = (SHW + PIPE_STAGES - 1) / PIPE_STAGES;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_ROR = 2'b10,
    OP_SRA = 2'b11
  } op_e;

  typedef struct packed {
    logic             valid;
    logic             sign;
    op_e              op;
    logic [SHW-1:0]   amt;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  data;
  } stage_t;

  stage_t in_stage;
  stage_t src  [PIPE_STAGES];
  stage_t st_d [PIPE_STAGES];
  stage_t st_q [PIPE_STAGES];
  logic   stall;
  logic   unused_bits;

  function automatic logic [XLEN-1:0] shift_level(input op_e op, input logic sign,
                                                  input logic [XLEN-1:0] d, input int n);
    logic [XLEN-1:0] r;
    case (op)
      OP_SRL:  r = d >> n;
      OP_SRA:  r = (d >> n) | ({XLEN{sign}} << (XLEN - n));
`ifdef RV_SHIFTER_ROTATE_EN
      OP_ROR:  r = (d >> n) | (d << (XLEN - n));
`endif
      default: r = d << n;
    endcase
    return r;
  endfunction

  // Stage k owns levels SHW-1-k*LPS downward; the amount field keeps all bits for simplicity.
  function automatic stage_t run_stage(input stage_t s, input int k);
    stage_t r;
    r = s;
    for (int lvl = SHW - 1; lvl >= 0; lvl--) begin
      if ((SHW - 1 - lvl) / LPS == k && s.amt[lvl])
        r.data = shift_level(s.op, s.sign, r.data, 1 << lvl);
    end
    return r;
  endfunction

  // NOTE: every field is assigned on every pass through always_comb, so no latch is inferred.
  always_comb begin
    in_stage       = '0;
    in_stage.valid = bus.in_valid;
    in_stage.sign  = bus.in_rs1[XLEN-1];
`ifdef RV_SHIFTER_ROTATE_EN
    in_stage.op    = op_e'(bus.in_op);
`else
    in_stage.op    = (op_e'(bus.in_op) == OP_ROR) ? OP_SLL : op_e'(bus.in_op);
`endif
    in_stage.amt   = bus.in_imm ? bus.in_instr[20 +: SHW] : bus.in_rs2[SHW-1:0];
    in_stage.tag   = bus.in_tag;
    in_stage.data  = bus.in_rs1;
  end

  always_comb begin
    src[0] = in_stage;
    for (int k = 1; k < PIPE_STAGES; k++) src[k] = st_q[k-1];
    for (int k = 0; k < PIPE_STAGES; k++) st_d[k] = run_stage(src[k], k);
  end

  // The whole pipe freezes only when a finished result is waiting on the consumer.
  assign stall = st_q[PIPE_STAGES-1].valid && !bus.out_ready;

  // NOTE: sequential state uses non-blocking assignments so all stages shift in lockstep.
  // NOTE: only valid bits and the output register are reset; inner datapath is don't-care while invalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < PIPE_STAGES; k++) st_q[k].valid <= 1'b0;
      st_q[PIPE_STAGES-1].data <= '0;
      st_q[PIPE_STAGES-1].tag  <= '0;
    end else if (flush) begin
      for (int k = 0; k < PIPE_STAGES; k++) st_q[k].valid <= 1'b0;
    end else if (!stall) begin
      for (int k = 0; k < PIPE_STAGES; k++) st_q[k] <= st_d[k];
    end
  end

  assign bus.in_ready  = !stall;
  assign bus.out_valid = st_q[PIPE_STAGES-1].valid;
  assign bus.out_data  = st_q[PIPE_STAGES-1].data;
  assign bus.out_tag   = st_q[PIPE_STAGES-1].tag;

  // Only the low SHW bits of the amount sources matter.
  assign unused_bits = ^{bus.in_instr, bus.in_rs2};
endmodule
